execute_cycle: RTL and testbench

- EX stage of the 5-stage RV32I pipeline.
- Consumes the ID/EX register outputs of the decode stage and selects forwarded operands. Runs the ALU, resolves branch/jump redirect, and registers results into the EX/MEM pipeline register.
- PCSrcE/PCTargetE feed the fetch stage.
- ALUResultM is fed back to itself for forwarding.

---
 rtl/execute_cycle.sv | 180 ++++++++++++++++++
 tb/tb_execute_cycle.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of the 5-stage RV32I pipeline.
// Selects the forwarded operands, runs the ALU, resolves branch/jal
// redirect combinationally and registers results into EX/MEM.
// Optional build macro EXE_BRANCH_CNT_EN adds a registered taken-redirect
// counter on output TakenCntE.

// Operand forward select: 00/11 register file, 01 writeback, 10 EX/MEM.
module exe_fwd_mux #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] rf,
  input  logic [XLEN-1:0] wb,
  input  logic [XLEN-1:0] mem,
  output logic [XLEN-1:0] y
);
  // Selected operand; 11 falls back to the register-file value.
  always_comb begin
    y = rf;
    case (sel)
      2'b01:   y = wb;
      2'b10:   y = mem;
      default: y = rf;
    endcase
  end
endmodule

// Integer ALU; carry and overflow are discarded, results wrap at XLEN.
module exe_alu #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y,
  output logic            zero
);
  logic lt;

  // Signed less-than for slt.
  assign lt = $signed(a) < $signed(b);

  // Operation decode; unused encodings produce zero.
  always_comb begin
    y = '0;
    case (op)
      3'b000:  y = a + b;
      3'b001:  y = a - b;
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      3'b101:  y = {{(XLEN-1){1'b0}}, lt};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);
endmodule

module execute_cycle #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             ALUSrcE,
  input  logic             MemWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic [2:0]       ALUControlE,
  input  logic             branchE,
  input  logic             JumpE,
  input  logic [XLEN-1:0]  RD1E,
  input  logic [XLEN-1:0]  RD2E,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  ImmEXTE,
  input  logic [XLEN-1:0]  PCPlus4E,
  input  logic [RADDR-1:0] RdE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [XLEN-1:0]  ResultW,
  output logic             PCSrcE,
  output logic [XLEN-1:0]  PCTargetE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [RADDR-1:0] RdM,
  output logic [XLEN-1:0]  ALUResultM,
  output logic [XLEN-1:0]  WriteDataM,
  output logic [XLEN-1:0]  PCPlus4M
`ifdef EXE_BRANCH_CNT_EN
  ,
  output logic [31:0]      TakenCntE
`endif
);

  // EX/MEM payload, captured as one unit every cycle.
  typedef struct packed {
    logic             reg_write;
    logic             mem_write;
    logic [1:0]       result_src;
    logic [RADDR-1:0] rd;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  write_data;
    logic [XLEN-1:0]  pc_plus4;
  } exmem_t;

  exmem_t          exmem_d, exmem_q;
  logic [XLEN-1:0] src_a, src_b_fwd, src_b, alu_result;
  logic            zero;

  // Forward from EX/MEM uses the value captured at the previous edge.
  exe_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .sel (ForwardAE),
    .rf  (RD1E),
    .wb  (ResultW),
    .mem (exmem_q.alu_result),
    .y   (src_a)
  );

  exe_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .sel (ForwardBE),
    .rf  (RD2E),
    .wb  (ResultW),
    .mem (exmem_q.alu_result),
    .y   (src_b_fwd)
  );

  assign src_b = ALUSrcE ? ImmEXTE : src_b_fwd;

  exe_alu #(.XLEN(XLEN)) u_alu (
    .op   (ALUControlE),
    .a    (src_a),
    .b    (src_b),
    .y    (alu_result),
    .zero (zero)
  );

  // Redirect is purely combinational; no reset gating, inputs are zero then.
  assign PCTargetE = PCE + ImmEXTE;
  assign PCSrcE    = (branchE & zero) | JumpE;

  // Next EX/MEM contents; store data is the forwarded rs2, never the immediate.
  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = RegWriteE;
    exmem_d.mem_write  = MemWriteE;
    exmem_d.result_src = ResultSrcE;
    exmem_d.rd         = RdE;
    exmem_d.alu_result = alu_result;
    exmem_d.write_data = src_b_fwd;
    exmem_d.pc_plus4   = PCPlus4E;
  end

  // EX/MEM register; async clear drops any in-flight instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exmem_q <= '0;
    else      exmem_q <= exmem_d;
  end

  assign RegWriteM  = exmem_q.reg_write;
  assign MemWriteM  = exmem_q.mem_write;
  assign ResultSrcM = exmem_q.result_src;
  assign RdM        = exmem_q.rd;
  assign ALUResultM = exmem_q.alu_result;
  assign WriteDataM = exmem_q.write_data;
  assign PCPlus4M   = exmem_q.pc_plus4;

`ifdef EXE_BRANCH_CNT_EN
  logic [31:0] taken_cnt;

  // Count cycles that redirect fetch; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        taken_cnt <= '0;
    else if (PCSrcE) taken_cnt <= taken_cnt + 32'd1;
  end

  assign TakenCntE = taken_cnt;
`endif

endmodule

// File: tb/tb_execute_cycle.sv
// Self-checking bench for execute_cycle: directed literal cases plus a
// randomized stream compared every negedge against a behavioural model.
module tb_execute_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, branchE, JumpE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmEXTE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic        PCSrcE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
`ifdef EXE_BRANCH_CNT_EN
  logic [31:0] TakenCntE;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .branchE(branchE), .JumpE(JumpE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmEXTE(ImmEXTE),
    .PCPlus4E(PCPlus4E), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
`ifdef EXE_BRANCH_CNT_EN
    , .TakenCntE(TakenCntE)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_regw, m_memw;
  logic [1:0]  m_rsrc;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4, m_cnt;
  logic        preload = 1'b0;

  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (s == 2'b01) return wb;
    if (s == 2'b10) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  logic [31:0] e_a, e_bf, e_res, e_tgt;
  logic        e_pcsrc;
  always_comb begin
    e_a     = pick(ForwardAE, RD1E, ResultW, m_alu);
    e_bf    = pick(ForwardBE, RD2E, ResultW, m_alu);
    e_res   = alu_ref(ALUControlE, e_a, ALUSrcE ? ImmEXTE : e_bf);
    e_tgt   = PCE + ImmEXTE;
    e_pcsrc = (branchE && e_res == 32'd0) || JumpE;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_regw <= 0; m_memw <= 0; m_rsrc <= 0; m_rd <= 0;
      m_alu <= 0; m_wd <= 0; m_pc4 <= 0; m_cnt <= 0;
    end else begin
      m_regw <= RegWriteE; m_memw <= MemWriteE; m_rsrc <= ResultSrcE; m_rd <= RdE;
      m_alu <= e_res; m_wd <= e_bf; m_pc4 <= PCPlus4E;
      m_cnt <= (preload ? 32'hFFFF_FFFF : m_cnt) + {31'd0, e_pcsrc};
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("pcsrc", {31'd0, PCSrcE}, {31'd0, e_pcsrc});
    chk("pctarget", PCTargetE, e_tgt);
    chk("regwrite_m", {31'd0, RegWriteM}, {31'd0, m_regw});
    chk("memwrite_m", {31'd0, MemWriteM}, {31'd0, m_memw});
    chk("resultsrc_m", {30'd0, ResultSrcM}, {30'd0, m_rsrc});
    chk("rd_m", {27'd0, RdM}, {27'd0, m_rd});
    chk("alu_m", ALUResultM, m_alu);
    chk("wdata_m", WriteDataM, m_wd);
    chk("pc4_m", PCPlus4M, m_pc4);
`ifdef EXE_BRANCH_CNT_EN
    if (!preload) chk("taken_cnt", TakenCntE, m_cnt);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic clear_in();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; ALUControlE = 0;
    branchE = 0; JumpE = 0; RD1E = 0; RD2E = 0; PCE = 0; ImmEXTE = 0;
    PCPlus4E = 0; RdE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_m_zero(input string nm);
    chk({nm, "_alu"}, ALUResultM, 32'd0);
    chk({nm, "_wd"}, WriteDataM, 32'd0);
    chk({nm, "_pc4"}, PCPlus4M, 32'd0);
    chk({nm, "_ctl"}, {24'd0, RegWriteM, MemWriteM, ResultSrcM, RdM}, 32'd0);
  endtask

  initial begin
    clear_in();
    rst = 0;
    repeat (3) step();
    chk_m_zero("cold_reset");
    rst = 1;

    // add / sub
    RD1E = 7; RD2E = 5; RegWriteE = 1; RdE = 5'd3; PCPlus4E = 32'h44; ResultSrcE = 2'd2;
    step();
    chk("add", ALUResultM, 32'd12);
    chk("add_rd", {27'd0, RdM}, 32'd3);
    chk("add_pc4", PCPlus4M, 32'h44);
    ALUControlE = 3'b001;
    step();
    chk("sub", ALUResultM, 32'd2);
    RD1E = 0; RD2E = 1;
    step();
    chk("sub_wrap", ALUResultM, 32'hFFFF_FFFF);
    chk("sub_wd", WriteDataM, 32'd1);

    // slt with immediate, undefined op
    RD1E = 32'hFFFF_FFFE; RD2E = 32'h55; ImmEXTE = 3; ALUSrcE = 1; ALUControlE = 3'b101;
    step();
    chk("slt_imm", ALUResultM, 32'd1);
    chk("wd_not_imm", WriteDataM, 32'h55);
    ALUControlE = 3'b110;
    step();
    chk("op110", ALUResultM, 32'd0);

    // forwarding
    ALUSrcE = 0; ALUControlE = 0; RD1E = 32'h10; RD2E = 0;
    step();
    chk("fwd_setup", ALUResultM, 32'h10);
    RD1E = 32'hDEAD; RD2E = 32'hBEEF; ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h20;
    step();
    chk("fwd_add", ALUResultM, 32'h30);
    ForwardAE = 0; RD1E = 32'h100; ALUSrcE = 1; ImmEXTE = 4; MemWriteE = 1;
    step();
    chk("store_addr", ALUResultM, 32'h104);
    chk("store_data", WriteDataM, 32'h20);
    chk("store_we", {31'd0, MemWriteM}, 32'd1);

    // branch / jump (combinational)
    clear_in();
    branchE = 1; RD1E = 9; RD2E = 9; ALUControlE = 3'b001; PCE = 32'h100; ImmEXTE = 32'hFFFF_FFF8;
    #1;
    chk("beq_taken", {31'd0, PCSrcE}, 32'd1);
    chk("beq_target", PCTargetE, 32'hF8);
    RD2E = 8; #1;
    chk("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    branchE = 0; JumpE = 1; RD1E = 32'h1234; ALUControlE = 0; RegWriteE = 1; PCPlus4E = 32'h104;
    #1;
    chk("jal", {31'd0, PCSrcE}, 32'd1);
    step();

    // async reset mid-cycle with nonzero state
    chk("pre_reset_nonzero", {31'd0, ALUResultM != 0}, 32'd1);
    #2 rst = 0; #1;
    chk_m_zero("async_reset");
    repeat (3) step();
    chk_m_zero("held_reset");
    clear_in();
    rst = 1;

`ifdef EXE_BRANCH_CNT_EN
    // three taken, one not taken
    branchE = 1; RD1E = 4; RD2E = 4; ALUControlE = 3'b001;
    repeat (3) step();
    RD2E = 5;
    step();
    chk("cnt_three", TakenCntE, 32'd3);
    #2 rst = 0; #1;
    chk("cnt_reset", TakenCntE, 32'd0);
    step(); rst = 1;
    // preload near wrap then one taken branch
    clear_in();
    step();
    preload = 1;
    force dut.taken_cnt = 32'hFFFF_FFFF;
    #1 release dut.taken_cnt;
    JumpE = 1;
    step();
    preload = 0;
    JumpE = 0;
    chk("cnt_wrap", TakenCntE, 32'd0);
`endif

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
      ResultSrcE = 2'($urandom); ALUControlE = 3'($urandom_range(0, 7));
      branchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
      RD1E = $urandom; RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
      PCE = $urandom; ImmEXTE = $urandom; PCPlus4E = $urandom; RdE = 5'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
      if (i == 200) begin
        #2 rst = 0;
        step(); step();
        rst = 1;
      end else begin
        step();
      end
    end

    clear_in();
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
